// File: rtl/rr_stage_pkg.sv
// Shared constants for the register-read stage: sizes and control-bundle bit positions.
package rr_stage_pkg;
    localparam int NREGS          = 8;
    localparam int IDX_W          = 3;
    localparam int DW             = 32;
    localparam int CTRL_W         = 7;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_USE_IMM   = 1;
endpackage

// File: rtl/reg32.sv
// One architectural register: async-reset storage with a write enable.
module reg32
    import rr_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/rr_scoreboard.sv
// Per-register busy bits tracking the single in-flight writer in EX.
module rr_scoreboard
    import rr_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-1:0] r_busy;

    // Flush beats everything; a new writer's set beats the retiring writer's clear.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_busy[gi] <= 1'b0;
                end else if (flush) begin
                    r_busy[gi] <= 1'b0;
                end else if (set_en && set_idx == IDX_W'(gi)) begin
                    r_busy[gi] <= 1'b1;
                end else if (clr_en && clr_idx == IDX_W'(gi)) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy = r_busy;
endmodule

// File: rtl/rr_stage.sv
// Register-read stage: regfile with writeback bypass, RAW hazard detection and bubble/stall control.
module rr_stage
    import rr_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        instr_length_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [IDX_W-1:0]  src1_idx,
    input  logic [IDX_W-1:0]  src2_idx,
    input  logic [IDX_W-1:0]  dst_idx_in,
    input  logic [DW-1:0]     imm_in,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DW-1:0]     wb_data,
    output logic [31:0]       pc_out,
    output logic [2:0]        instr_length_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [IDX_W-1:0]  dst_idx_out,
    output logic [DW-1:0]     src1_out,
    output logic [DW-1:0]     src2_out,
    output logic              valid_out,
    output logic              stall_out
);
    logic [DW-1:0]    w_rf [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_use_imm;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_hazard;
    logic             w_issue;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            reg32 u_reg (
                .clk  (clk),
                .rst  (rst),
                .i_we (wb_valid && wb_idx == IDX_W'(gi)),
                .i_d  (wb_data),
                .o_q  (w_rf[gi])
            );
        end
    endgenerate

    rr_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (w_issue && ctrl_in[CTRL_REG_WRITE]),
        .set_idx (dst_idx_in),
        .clr_en  (wb_valid),
        .clr_idx (wb_idx),
        .flush   (flush),
        .busy    (w_busy)
    );

    // A writeback landing this cycle both supplies the operand and resolves its hazard.
    always_comb begin
        w_use_imm = ctrl_in[CTRL_USE_IMM];
        w_fwd1    = wb_valid && (wb_idx == src1_idx);
        w_fwd2    = wb_valid && (wb_idx == src2_idx);
        src1_out  = w_fwd1 ? wb_data : w_rf[src1_idx];
        src2_out  = w_use_imm ? imm_in : (w_fwd2 ? wb_data : w_rf[src2_idx]);
        w_hazard  = valid_in && ((w_busy[src1_idx] && !w_fwd1) ||
                                 (w_busy[src2_idx] && !w_use_imm && !w_fwd2));
        w_issue   = valid_in && !w_hazard && !stall_in && !flush;
        valid_out = valid_in && !w_hazard && !flush;
        stall_out = stall_in || w_hazard;
    end

    assign pc_out           = pc_in;
    assign instr_length_out = instr_length_in;
    assign ctrl_out         = ctrl_in;
    assign dst_idx_out      = dst_idx_in;
endmodule

// File: tb/tb_rr_stage.sv
// Bench for rr_stage: behavioural regfile/busy model checked every cycle, plus directed literal checks.
module tb_rr_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [2:0]  instr_length_in;
    logic [6:0]  ctrl_in;
    logic [2:0]  src1_idx, src2_idx, dst_idx_in;
    logic [31:0] imm_in;
    logic        stall_in, flush, wb_valid;
    logic [2:0]  wb_idx;
    logic [31:0] wb_data;
    logic [31:0] pc_out;
    logic [2:0]  instr_length_out;
    logic [6:0]  ctrl_out;
    logic [2:0]  dst_idx_out;
    logic [31:0] src1_out, src2_out;
    logic        valid_out, stall_out;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_rf [8];
    logic [7:0]  m_busy;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_WR   = 7'b0000001;
    localparam logic [6:0] C_IMM  = 7'b0000010;

    always #5 clk = ~clk;

    rr_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
        .instr_length_in(instr_length_in), .ctrl_in(ctrl_in),
        .src1_idx(src1_idx), .src2_idx(src2_idx), .dst_idx_in(dst_idx_in),
        .imm_in(imm_in), .stall_in(stall_in), .flush(flush),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .pc_out(pc_out), .instr_length_out(instr_length_out), .ctrl_out(ctrl_out),
        .dst_idx_out(dst_idx_out), .src1_out(src1_out), .src2_out(src2_out),
        .valid_out(valid_out), .stall_out(stall_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [2:0] idx);
        if (wb_valid && wb_idx == idx) return wb_data;
        return m_rf[idx];
    endfunction

    // Does the instruction presented now depend on a result that is not yet available?
    function automatic logic model_hazard();
        logic blocked1, blocked2;
        blocked1 = m_busy[src1_idx] && !(wb_valid && wb_idx == src1_idx);
        blocked2 = m_busy[src2_idx] && !ctrl_in[1] && !(wb_valid && wb_idx == src2_idx);
        return valid_in && (blocked1 || blocked2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_busy = '0;
    endtask

    task automatic check_all();
        logic hz;
        hz = model_hazard();
        chk("pc_out", pc_out, pc_in);
        chk("len_out", 32'(instr_length_out), 32'(instr_length_in));
        chk("ctrl_out", 32'(ctrl_out), 32'(ctrl_in));
        chk("dst_out", 32'(dst_idx_out), 32'(dst_idx_in));
        chk("src1_out", src1_out, operand(src1_idx));
        chk("src2_out", src2_out, ctrl_in[1] ? imm_in : operand(src2_idx));
        chk("valid_out", 32'(valid_out), 32'(valid_in && !hz && !flush));
        chk("stall_out", 32'(stall_out), 32'(stall_in || hz));
    endtask

    task automatic model_edge();
        logic hz, issue;
        hz    = model_hazard();
        issue = valid_in && !hz && !stall_in && !flush;
        if (wb_valid) m_rf[wb_idx] = wb_data;
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wb_valid) m_busy[wb_idx] = 1'b0;
            if (issue && ctrl_in[0]) m_busy[dst_idx_in] = 1'b1;
        end
    endtask

    // Sample mid-cycle, then advance across the edge and let the model follow.
    task automatic settle();
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d);
        valid_in = v; ctrl_in = c; src1_idx = s1; src2_idx = s2; dst_idx_in = d;
        pc_in = pc_in + 32'd4;
        instr_length_in = instr_length_in + 3'd1;
    endtask

    task automatic idle_inputs();
        stall_in = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
        imm_in = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        pc_in = 32'h1000; instr_length_in = 3'd2;
        drive(1'b0, C_NONE, 3'd0, 3'd0, 3'd0);
        idle_inputs();
        stall_in = 1'b1;
        model_reset();
        #3;
        check_all();
        chk("rst_stall_passthru", 32'(stall_out), 32'd1);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stall_in = 1'b0;
        tick();

        // Reset then read
        drive(1'b1, C_NONE, 3'd3, 3'd5, 3'd0);
        settle();
        chk("read_src1", src1_out, 32'h0);
        chk("read_src2", src2_out, 32'h0);
        chk("read_valid", 32'(valid_out), 32'd1);
        chk("read_stall", 32'(stall_out), 32'd0);
        tick();

        // Write-through bypass, then stored value
        drive(1'b1, C_NONE, 3'd2, 3'd5, 3'd0);
        wb_valid = 1'b1; wb_idx = 3'd2; wb_data = 32'hDEADBEEF;
        settle();
        chk("bypass_src1", src1_out, 32'hDEADBEEF);
        tick();
        idle_inputs();
        settle();
        chk("stored_src1", src1_out, 32'hDEADBEEF);
        tick();

        // RAW hazard, resolved late with EX held by stall_in
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd4);
        settle();
        tick();
        drive(1'b1, C_NONE, 3'd0, 3'd4, 3'd0);
        for (int i = 0; i < 4; i++) begin
            stall_in = (i == 1 || i == 2);
            settle();
            chk("raw_valid", 32'(valid_out), 32'd0);
            chk("raw_stall", 32'(stall_out), 32'd1);
            tick();
        end
        stall_in = 1'b0;
        wb_valid = 1'b1; wb_idx = 3'd4; wb_data = 32'h12345678;
        settle();
        chk("raw_fwd_src2", src2_out, 32'h12345678);
        chk("raw_fwd_valid", 32'(valid_out), 32'd1);
        chk("raw_fwd_stall", 32'(stall_out), 32'd0);
        tick();
        idle_inputs();

        // Immediate masks a busy src2
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd6);
        settle();
        tick();
        drive(1'b1, C_IMM, 3'd0, 3'd6, 3'd0);
        imm_in = 32'h10;
        settle();
        chk("imm_stall", 32'(stall_out), 32'd0);
        chk("imm_src2", src2_out, 32'h10);
        tick();
        idle_inputs();

        // Flush kills the bubble source and clears the scoreboard
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd1);
        settle();
        tick();
        drive(1'b1, C_NONE, 3'd1, 3'd0, 3'd0);
        flush = 1'b1;
        settle();
        chk("flush_valid", 32'(valid_out), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("post_flush_stall", 32'(stall_out), 32'd0);
        chk("post_flush_valid", 32'(valid_out), 32'd1);
        tick();

        // Set wins over same-cycle clear of r7
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd7);
        settle();
        tick();
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd7);
        wb_valid = 1'b1; wb_idx = 3'd7; wb_data = 32'hA5A5A5A5;
        settle();
        tick();
        idle_inputs();
        drive(1'b1, C_NONE, 3'd7, 3'd0, 3'd0);
        settle();
        chk("setclr_stall", 32'(stall_out), 32'd1);
        tick();
        wb_valid = 1'b1; wb_idx = 3'd7; wb_data = 32'h0BADF00D;
        settle();
        chk("setclr_fwd", src1_out, 32'h0BADF00D);
        tick();
        idle_inputs();

        // A writer held by stall_in does not mark its destination busy
        drive(1'b1, C_WR, 3'd0, 3'd0, 3'd5);
        stall_in = 1'b1;
        settle();
        tick();
        stall_in = 1'b0;
        drive(1'b1, C_NONE, 3'd5, 3'd0, 3'd0);
        settle();
        chk("held_writer_stall", 32'(stall_out), 32'd0);
        tick();

        // Mixed traffic checked against the model only
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom), 7'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            imm_in   = $urandom;
            stall_in = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            wb_valid = ($urandom_range(0, 1) == 0);
            wb_idx   = 3'($urandom);
            wb_data  = $urandom;
            settle();
            tick();
        end
        idle_inputs();

        // Asynchronous reset mid-cycle: state clears without a clock edge
        drive(1'b1, C_NONE, 3'd2, 3'd2, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_src1", src1_out, 32'h0);
        #1;
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_stage.md
Name: rr_stage

Overview:
- Register-read stage: sits between decode and the rr_ex_pr pipeline register, and feeds that register directly.
- Holds the architectural 8x32 register file and a per-register busy scoreboard.
- Reads operands with writeback bypass, and detects RAW hazards against the in-flight writer.
- Inserts bubbles on a hazard and generates stall_out upstream.
- Sole in-flight writer is the instruction in EX; EX writes back at the clock edge that ends its last cycle.

Parameters:
- NREGS, 8, number of architectural registers (index width 3)
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_in  in  1  decode has an instruction
- pc_in  in  32  instruction PC
- instr_length_in  in  3  instruction length in bytes
- ctrl_in  in  7  control bundle; bit 0 = REG_WRITE, bit 1 = USE_IMM, bits 6:2 pass through
- src1_idx  in  3  source 1 register index
- src2_idx  in  3  source 2 register index
- dst_idx_in  in  3  destination register index
- imm_in  in  32  immediate; replaces src2 when USE_IMM=1
- stall_in  in  1  EX/rr_ex_pr is holding
- flush  in  1  branch redirect raised by EX
- wb_valid  in  1  writeback this cycle
- wb_idx  in  3  writeback index
- wb_data  in  32  writeback data
- pc_out  out  32  to rr_ex_pr
- instr_length_out  out  3  to rr_ex_pr
- ctrl_out  out  7  to rr_ex_pr
- dst_idx_out  out  3  to rr_ex_pr
- src1_out  out  32  to rr_ex_pr
- src2_out  out  32  to rr_ex_pr
- valid_out  out  1  to rr_ex_pr
- stall_out  out  1  to fetch/decode; hold the current instruction

Behaviour:
- Reset (async, rst=1):
  - all NREGS registers = 0; all busy bits = 0
  - outputs are combinational from state and inputs; with valid_in=0 they give valid_out=0, stall_out=stall_in
- Operand read (combinational, zero latency):
  - srcN_raw = wb_data if (wb_valid && wb_idx==srcN_idx), else regfile[srcN_idx]
  - src1_out = src1_raw
  - src2_out = imm_in if USE_IMM, else src2_raw
- Hazard:
  - hz1 = busy[src1_idx] && !(wb_valid && wb_idx==src1_idx)
  - hz2 = busy[src2_idx] && !USE_IMM && !(wb_valid && wb_idx==src2_idx)
  - hazard = valid_in && (hz1 || hz2)
- valid_out = valid_in && !hazard && !flush (bubble on a hazard or a flush).
- stall_out = stall_in || hazard.
- pc_out, instr_length_out, ctrl_out and dst_idx_out pass through unchanged.
- issue = valid_in && !hazard && !stall_in && !flush.
- Regfile write: on a clock edge with wb_valid, regfile[wb_idx] <= wb_data. The write is always performed, including during flush or stall.
- Scoreboard update per register r at a clock edge:
  - flush: busy <= 0 for all r. The EX instruction raising flush never writes, so no older writer remains outstanding.
  - else if issue && REG_WRITE && dst_idx_in==r: busy[r] <= 1. Set wins over a same-cycle clear of the same r.
  - else if wb_valid && wb_idx==r: busy[r] <= 0.
  - else: busy[r] holds.
- A busy bit with no writeback holds indefinitely; the bench checks that no hazard deadlock occurs when wb arrives late (multi-cycle EX under stall_in).
- Reset mid-operation clears state immediately, with no dependence on clk.
- Index and width rules: indices are 3-bit, no out-of-range case; data is passed with no arithmetic.

Decomposition:
- Shared package holds:
  - CTRL_REG_WRITE = 0, CTRL_USE_IMM = 1
  - CTRL_W = 7, IDX_W = 3, DW = 32
- One sub-module: rr_scoreboard.
  - Inputs: set_en, set_idx, clr_en, clr_idx, flush
  - Output: busy[7:0]
  - Carries the priority rules above.
- The register file stays inline, built from reg32 instances with a write-enable decode.

Test Plan:
- Reset, then read: rst pulse; src1_idx=3, src2_idx=5, valid_in=1 -> src1_out=0, src2_out=0, valid_out=1, stall_out=0.
- Write-through bypass: wb_valid=1, wb_idx=2, wb_data=0xDEADBEEF while src1_idx=2 -> same cycle src1_out=0xDEADBEEF; next cycle regfile[2] reads 0xDEADBEEF.
- RAW hazard: issue a writer with dst=4 and REG_WRITE=1, then a reader with src2_idx=4 and no wb -> valid_out=0, stall_out=1 for every cycle until wb_idx=4 arrives; that cycle the forwarded data is output with valid_out=1 and stall_out=0.
- Immediate masks hazard: busy[6]=1; reader has src2_idx=6, USE_IMM=1, imm_in=0x10, src1 not busy -> no stall, src2_out=0x10.
- Flush: busy[1]=1 and flush=1 with valid_in=1 -> valid_out=0; the next cycle has busy all 0 and a reader of r1 proceeds without stall.
- Simultaneous set/clear: wb_idx=7 while issuing a new writer with dst=7 -> busy[7]=1 afterwards; a following reader of r7 stalls.
